// File: rtl/axis2fifo_pack_pkg.sv
// Shared definitions for the pixel packer and the FIFO read side:
// state encoding, lane count and lane bit placement.
package axis2fifo_pack_pkg;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    PACK     = 1'b1
  } pack_state_e;

  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_IDX_W = 2;

  typedef logic [LANE_IDX_W-1:0] lane_t;

  // Lane 0 occupies the most significant pixel slot of the word.
  function automatic int unsigned lane_lsb(input lane_t lane, input int unsigned pix_w);
    return (LANES - 1 - 32'(lane)) * pix_w;
  endfunction

endpackage

// File: rtl/axis2fifo_pack_if.sv
// Pixel stream input and FIFO write port of the packer, grouped as one bus.
interface axis2fifo_pack_if #(
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned FDW             = 128
);
  logic                         S_AXIS_TREADY;
  logic [AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA;
  logic [AXIS_DATA_WIDTH/8-1:0] S_AXIS_TSTRB;
  logic                         S_AXIS_TLAST;
  logic                         S_AXIS_TVALID;
  logic                         S_AXIS_USER;
  logic                         fwr_rdy;
  logic                         fwr_vld;
  logic [FDW-1:0]               fwr_dout;

  modport slave (
    output S_AXIS_TREADY, fwr_vld, fwr_dout,
    input  S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_USER, fwr_rdy
  );

  modport master (
    input  S_AXIS_TREADY, fwr_vld, fwr_dout,
    output S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_USER, fwr_rdy
  );
endinterface

// File: rtl/pack_out_reg.sv
// One-word valid/ready holding register between the packer and the FIFO.
module pack_out_reg #(
  parameter int unsigned W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_vld,
  input  logic [W-1:0] load_data,
  output logic         load_rdy_c,
  output logic         word_vld,
  output logic [W-1:0] word_data,
  input  logic         word_rdy
);

  // Free when empty or when the held word drains this cycle.
  assign load_rdy_c = !word_vld || word_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_vld  <= 1'b0;
      word_data <= '0;
    end else if (load_vld) begin
      word_vld  <= 1'b1;
      word_data <= load_data;
    end else if (word_rdy) begin
      word_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/axis2fifo_pack.sv
// Packs four accepted AXI-Stream pixels into one FIFO word, with frame
// synchronisation on USER and line-length error tracking.
module axis2fifo_pack
  import axis2fifo_pack_pkg::*;
#(
  parameter int unsigned FDW               = 128,
  parameter int unsigned FAW               = 8,
  parameter int unsigned AXIS_DATA_WIDTH   = 32,
  parameter int unsigned PIXELS_HORIZONTAL = 1280,
  parameter int unsigned PIXELS_VERTICAL   = 1024
) (
  input  logic                    S_AXIS_ACLK,
  input  logic                    S_AXIS_ARESETN,
  axis2fifo_pack_if.slave         bus,
  output logic                    sof_pulse,
  output logic                    err_short,
  output logic                    err_long
);

  localparam int unsigned PW  = AXIS_DATA_WIDTH;
  localparam int unsigned PCW = $clog2(PIXELS_HORIZONTAL) + 1;
  localparam int unsigned LCW = $clog2(PIXELS_VERTICAL) + 1;
  localparam logic [PCW-1:0] PIX_LAST  = PCW'(PIXELS_HORIZONTAL - 1);
  localparam logic [LCW-1:0] LINE_LAST = LCW'(PIXELS_VERTICAL - 1);

  pack_state_e    state, state_nxt;
  lane_t          lane, lane_nxt;
  logic [PCW-1:0] pix_cnt, pix_nxt;
  logic [LCW-1:0] line_cnt, line_nxt;
  logic [FDW-1:0] acc, acc_nxt, word_c;
  logic           run;
  logic           emit;
  logic           sof_nxt;
  logic           err_short_set, err_long_set;
  logic           out_rdy_c;
  logic           accept, user, line_end, frame_end;

  logic [FAW-1:0] unused_faw;
  logic           unused_strb;
  assign unused_faw  = '0;
  assign unused_strb = ^bus.S_AXIS_TSTRB;

  // Ready stays low until the first clock after reset release.
  assign bus.S_AXIS_TREADY = run && ((state == WAIT_SOF) || out_rdy_c);

  assign accept    = bus.S_AXIS_TVALID && bus.S_AXIS_TREADY;
  assign user      = bus.S_AXIS_USER;
  assign line_end  = accept && !user && (state == PACK) &&
                     (bus.S_AXIS_TLAST || (pix_cnt >= PIX_LAST));
  assign frame_end = line_end && (line_cnt >= LINE_LAST);
  assign word_c    = acc | (FDW'(bus.S_AXIS_TDATA) << lane_lsb(lane, PW));

  // State register.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) state <= WAIT_SOF;
    else                 state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_SOF: if (accept && user) state_nxt = PACK;
      PACK: begin
        if (accept && user) state_nxt = PACK;
        else if (frame_end) state_nxt = WAIT_SOF;
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  // Datapath and flag controls.
  always_comb begin
    acc_nxt       = acc;
    lane_nxt      = lane;
    pix_nxt       = pix_cnt;
    line_nxt      = line_cnt;
    emit          = 1'b0;
    sof_nxt       = 1'b0;
    err_short_set = 1'b0;
    err_long_set  = 1'b0;
    if (accept) begin
      if (user) begin
        // USER always restarts the frame; any partial word is dropped.
        acc_nxt       = FDW'(bus.S_AXIS_TDATA) << lane_lsb(lane_t'(0), PW);
        lane_nxt      = lane_t'(1);
        pix_nxt       = PCW'(1);
        line_nxt      = '0;
        sof_nxt       = 1'b1;
        err_short_set = (state == PACK) && (lane != lane_t'(0));
      end else if (state == PACK) begin
        if (line_end) begin
          emit          = 1'b1;
          acc_nxt       = '0;
          lane_nxt      = '0;
          pix_nxt       = '0;
          line_nxt      = frame_end ? '0 : line_cnt + LCW'(1);
          err_short_set = bus.S_AXIS_TLAST && (pix_cnt < PIX_LAST);
          err_long_set  = !bus.S_AXIS_TLAST;
        end else if (lane == lane_t'(LANES - 1)) begin
          emit     = 1'b1;
          acc_nxt  = '0;
          lane_nxt = '0;
          pix_nxt  = pix_cnt + PCW'(1);
        end else begin
          acc_nxt  = word_c;
          lane_nxt = lane + lane_t'(1);
          pix_nxt  = pix_cnt + PCW'(1);
        end
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      run       <= 1'b0;
      lane      <= '0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      acc       <= '0;
      sof_pulse <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      run       <= 1'b1;
      lane      <= lane_nxt;
      pix_cnt   <= pix_nxt;
      line_cnt  <= line_nxt;
      acc       <= acc_nxt;
      sof_pulse <= sof_nxt;
      err_short <= err_short | err_short_set;
      err_long  <= err_long | err_long_set;
    end
  end

  pack_out_reg #(.W(FDW)) u_out (
    .clk        (S_AXIS_ACLK),
    .rst_n      (S_AXIS_ARESETN),
    .load_vld   (emit),
    .load_data  (word_c),
    .load_rdy_c (out_rdy_c),
    .word_vld   (bus.fwr_vld),
    .word_data  (bus.fwr_dout),
    .word_rdy   (bus.fwr_rdy)
  );

endmodule

// File: tb/tb_axis2fifo_pack.sv
// Scoreboard bench for axis2fifo_pack: directed pixel streams push expected
// FIFO words; a negedge monitor pops and compares each write.
module tb_axis2fifo_pack;
  localparam int unsigned PW  = 32;
  localparam int unsigned FDW = 128;
  localparam int unsigned PH  = 1280;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sof_pulse, err_short, err_long;

  axis2fifo_pack_if #(.AXIS_DATA_WIDTH(PW), .FDW(FDW)) bus ();

  axis2fifo_pack #(
    .FDW(FDW), .FAW(8), .AXIS_DATA_WIDTH(PW),
    .PIXELS_HORIZONTAL(PH), .PIXELS_VERTICAL(4)
  ) u_dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .bus            (bus.slave),
    .sof_pulse      (sof_pulse),
    .err_short      (err_short),
    .err_long       (err_long)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int wr_base = 0;
  logic [FDW-1:0] exp_q[$];
  logic held_v = 1'b0;
  logic [FDW-1:0] held_d = '0;
  logic saw_drop = 1'b0;

  task automatic chk(input string name, input logic [FDW-1:0] act, input logic [FDW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [FDW-1:0] w4(input logic [PW-1:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  // Monitor: every accepted FIFO write is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && bus.fwr_vld) chk("dout_stable", bus.fwr_dout, held_d);
      if (bus.fwr_vld && bus.fwr_rdy) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got %h want none", bus.fwr_dout);
        end else begin
          chk("write_data", bus.fwr_dout, exp_q.pop_front());
        end
      end
      held_v = bus.fwr_vld && !bus.fwr_rdy;
      held_d = bus.fwr_dout;
    end
  end

  task automatic idle_bus();
    bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_USER   = 1'b0;
    bus.S_AXIS_TLAST  = 1'b0;
    bus.S_AXIS_TDATA  = '0;
    bus.S_AXIS_TSTRB  = '1;
  endtask

  // Present one beat, wait for the handshake, then check sof_pulse.
  task automatic send(input logic [PW-1:0] d, input logic u, input logic l);
    logic ok;
    int budget;
    bus.S_AXIS_TDATA  = d;
    bus.S_AXIS_USER   = u;
    bus.S_AXIS_TLAST  = l;
    bus.S_AXIS_TVALID = 1'b1;
    ok = 1'b0;
    budget = 0;
    while (!ok && budget < 50) begin
      @(negedge clk);
      ok = bus.S_AXIS_TREADY;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!ok) chk("beat_timeout", 0, 1);
    else     chk("sof_pulse", FDW'(sof_pulse), FDW'(u));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_bus();
    #1;
    chk("rst_tready", FDW'(bus.S_AXIS_TREADY), 0);
    chk("rst_vld", FDW'(bus.fwr_vld), 0);
    chk("rst_dout", bus.fwr_dout, 0);
    chk("rst_sof", FDW'(sof_pulse), 0);
    chk("rst_errs", FDW'({err_short, err_long}), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_group(input string name, input int writes);
    idle_bus();
    repeat (20) @(posedge clk);
    #1;
    chk({name, "_drained"}, FDW'(exp_q.size()), 0);
    chk({name, "_writes"}, FDW'(wr_cnt - wr_base), FDW'(writes));
  endtask

  task automatic stall10();
    @(posedge clk);
    #1;
    bus.fwr_rdy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.S_AXIS_TREADY) saw_drop = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.fwr_rdy = 1'b1;
  endtask

  initial begin
    idle_bus();
    bus.fwr_rdy = 1'b1;

    // Group 1: junk before USER, first word latency, full line with a FIFO stall.
    apply_reset();
    wr_base = wr_cnt;
    for (int i = 0; i < 3; i++) send(32'hDEAD_0000 + 32'(i), 1'b0, 1'b0);
    for (int k = 0; k < PH / 4; k++)
      exp_q.push_back(w4(32'(4*k+1), 32'(4*k+2), 32'(4*k+3), 32'(4*k+4)));
    for (int i = 0; i < PH; i++) begin
      if (i == 200) fork stall10(); join_none
      send(32'(i + 1), i == 0, i == PH - 1);
      if (i == 3) chk("vld_latency", FDW'(bus.fwr_vld), 1);
    end
    finish_group("full_line", PH / 4);
    chk("full_line_errs", FDW'({err_short, err_long}), 0);
    chk("stall_tready_drop", FDW'(saw_drop), 1);

    // Group 2: short line of six pixels.
    apply_reset();
    wr_base = wr_cnt;
    exp_q.push_back(w4(32'd11, 32'd12, 32'd13, 32'd14));
    exp_q.push_back(w4(32'd15, 32'd16, 32'd0, 32'd0));
    for (int i = 0; i < 6; i++) send(32'(11 + i), i == 0, i == 5);
    finish_group("short_line", 2);
    chk("short_err_short", FDW'(err_short), 1);
    chk("short_err_long", FDW'(err_long), 0);

    // Group 3: USER arriving at lane 2 restarts the frame.
    apply_reset();
    wr_base = wr_cnt;
    send(32'h20, 1'b1, 1'b0);
    send(32'h21, 1'b0, 1'b0);
    chk("pre_resync_err_short", FDW'(err_short), 0);
    exp_q.push_back(w4(32'h30, 32'h31, 32'h32, 32'h33));
    for (int i = 0; i < 4; i++) send(32'h30 + 32'(i), i == 0, 1'b0);
    finish_group("resync", 1);
    chk("resync_err_short", FDW'(err_short), 1);
    chk("resync_err_long", FDW'(err_long), 0);

    // Group 4: overlong line (no TLAST), then three short lines end the frame.
    apply_reset();
    wr_base = wr_cnt;
    for (int k = 0; k < PH / 4; k++)
      exp_q.push_back(w4(32'h1000 + 32'(4*k), 32'h1001 + 32'(4*k),
                         32'h1002 + 32'(4*k), 32'h1003 + 32'(4*k)));
    for (int i = 0; i < PH; i++) send(32'h1000 + 32'(i), i == 0, 1'b0);
    #1;
    chk("long_err_long", FDW'(err_long), 1);
    chk("long_err_short", FDW'(err_short), 0);
    for (int ln = 1; ln < 4; ln++) begin
      exp_q.push_back(w4(32'(ln*16), 32'(ln*16+1), 32'(ln*16+2), 32'(ln*16+3)));
      for (int i = 0; i < 4; i++) send(32'(ln*16 + i), 1'b0, i == 3);
    end
    for (int i = 0; i < 4; i++) send(32'hBAD0 + 32'(i), 1'b0, 1'b0);
    finish_group("frame_end", PH / 4 + 3);
    chk("frame_err_short", FDW'(err_short), 1);

    // Group 5: reset while a word is held blocked.
    apply_reset();
    wr_base = wr_cnt;
    bus.fwr_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(i + 1), i == 0, 1'b0);
    idle_bus();
    @(negedge clk);
    chk("held_vld", FDW'(bus.fwr_vld), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", FDW'(bus.fwr_vld), 0);
    chk("async_rst_dout", bus.fwr_dout, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus.fwr_rdy = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) send(32'hEE00 + 32'(i), 1'b0, 1'b0);
    exp_q.push_back(w4(32'd5, 32'd6, 32'd7, 32'd8));
    for (int i = 0; i < 4; i++) send(32'(i + 5), i == 0, 1'b0);
    finish_group("post_reset", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis2fifo_pack.md
AXIS2FIFO_PACK -- requirements
Module: axis2fifo_pack

Interface
REQ-001 SHALL have parameter FDW, default 128, FIFO word width; SHALL equal 4*AXIS_DATA_WIDTH.
REQ-002 SHALL have parameter FAW, default 8, FIFO address width (port compatibility only).
REQ-003 SHALL have parameter AXIS_DATA_WIDTH, default 32, pixel width.
REQ-004 SHALL have parameter PIXELS_HORIZONTAL, default 1280, pixels per line; SHALL be a multiple of 4.
REQ-005 SHALL have parameter PIXELS_VERTICAL, default 1024, lines per frame.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, with ports:
- S_AXIS_ACLK  in  1  sole clock, rising edge
- S_AXIS_ARESETN  in  1  asynchronous active-low reset
- S_AXIS_TREADY  out  1  pixel accept
- S_AXIS_TDATA  in  AXIS_DATA_WIDTH  pixel
- S_AXIS_TSTRB  in  AXIS_DATA_WIDTH/8  ignored
- S_AXIS_TLAST  in  1  end of line
- S_AXIS_TVALID  in  1  pixel valid
- S_AXIS_USER  in  1  start of frame, qualified by TVALID&TREADY
- fwr_rdy  in  1  FIFO can accept a word
- fwr_vld  out  1  word valid
- fwr_dout  out  FDW  packed word
- sof_pulse  out  1  one-cycle pulse on each accepted USER beat
- err_short  out  1  sticky: line ended early
- err_long  out  1  sticky: line exceeded PIXELS_HORIZONTAL

Function
REQ-007 SHALL pack 4 consecutive accepted pixels per word: first pixel in fwr_dout[FDW-1:FDW-32], fourth in [31:0].
REQ-008 SHALL implement states WAIT_SOF and PACK; reset enters WAIT_SOF.
REQ-009 In WAIT_SOF: S_AXIS_TREADY=1; non-USER beats are discarded; an accepted USER beat is stored as lane 0 and moves to PACK.
REQ-010 In PACK: a 2-bit lane counter advances per accepted beat; the lane-3 beat plus lanes 0-2 load the output register in the same cycle (latency one cycle from 4th beat to fwr_vld=1).
REQ-011 Output register SHALL hold fwr_vld until fwr_vld&fwr_rdy; fwr_dout SHALL be stable while fwr_vld=1 and fwr_rdy=0.
REQ-012 S_AXIS_TREADY SHALL be !(fwr_vld & !fwr_rdy) in PACK (stall only while a held word is blocked); simultaneous drain and new-word load SHALL lose nothing.
REQ-013 A per-line pixel counter (width clog2(PIXELS_HORIZONTAL)+1) SHALL count accepted beats and clear on TLAST or USER.
REQ-014 TLAST at count < PIXELS_HORIZONTAL-1: SHALL zero-pad remaining lanes, emit the partial word, set err_short, reset lane to 0.
REQ-015 Beat at count = PIXELS_HORIZONTAL-1 without TLAST: line ends there; next beats belong to the next line; err_long set if it is not TLAST.
REQ-016 A line counter SHALL count completed lines; after PIXELS_VERTICAL lines the state SHALL return to WAIT_SOF.
REQ-017 USER accepted in PACK at lane != 0: partial accumulation SHALL be discarded, the beat taken as lane 0 of a new frame, line counter cleared, err_short set.
REQ-018 sof_pulse SHALL be high exactly the cycle after an accepted USER beat.
REQ-019 err_short/err_long SHALL clear only on reset.

Reset
REQ-020 While S_AXIS_ARESETN=0: state WAIT_SOF, lane 0, counters 0, fwr_vld=0, fwr_dout=0, sof_pulse=0, err flags 0; S_AXIS_TREADY=0.
REQ-021 Reset asserted mid-word SHALL discard the held word and partial accumulation; first cycle after deassertion SHALL be WAIT_SOF.

Structure
REQ-022 State encoding, lane count (4), and lane bit positions SHALL live in a shared package used with the FIFO read side.
REQ-023 The output holding register SHALL be a sub-module pack_out_reg (valid/ready, one word deep).

Verification
REQ-024 USER pixel 0x00000001 then 0x2,0x3,0x4 with fwr_rdy=1 -> one word 0x00000001_00000002_00000003_00000004, fwr_vld one cycle after 4th beat, sof_pulse one cycle.
REQ-025 Full 1280-pixel line, TLAST on last -> exactly 320 writes, err flags 0.
REQ-026 fwr_rdy=0 for 10 cycles during a frame -> TREADY drops after next completed word, no data lost or duplicated, dout stable.
REQ-027 TLAST after 6 pixels -> 2 writes, second = p4,p5,0,0; err_short=1.
REQ-028 Pixels before first USER -> no writes; USER mid-word (lane 2) -> partial dropped, new frame starts at lane 0, err_short=1.
REQ-029 Reset asserted with fwr_vld=1 and fwr_rdy=0 -> fwr_vld=0 immediately, WAIT_SOF after release.
